// File: rtl/nano_cpu_pkg.sv
// Shared nano-cpu definitions: ADD/ADDI encodings, sequencer state and trap
// cause enums, and the legality check used by the instruction sequencer.
package nano_cpu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [6:0] F7_ADD     = 7'b0000000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_HALT   = 3'd5
    } seq_state_e;

    typedef enum logic [1:0] {
        TRAP_NONE        = 2'd0,
        TRAP_ILLEGAL     = 2'd1,
        TRAP_ALU_TIMEOUT = 2'd2,
        TRAP_PC_OVERFLOW = 2'd3
    } trap_cause_e;

    // Only ADD (R-type) and ADDI (I-type) are executable on this datapath.
    function automatic logic is_legal_instr(input logic [31:0] instr);
        logic is_add;
        logic is_addi;
        is_add  = (instr[6:0] == OPC_OP) && (instr[14:12] == F3_ADD) &&
                  (instr[31:25] == F7_ADD);
        is_addi = (instr[6:0] == OPC_OP_IMM) && (instr[14:12] == F3_ADD);
        return is_add || is_addi;
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/issue/wait sequencer for the nano-cpu execute path.
// Handshake: alu_in_valid is a one-cycle issue pulse in ISSUE; the ALU answers
// with alu_out_valid L>=1 cycles later, which is only honoured while in WAIT.
module instr_sequencer
    import nano_cpu_pkg::*;
#(
    parameter int IMEM_DEPTH  = 1024,
    parameter int ALU_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_data,
    output logic [31:0]                   instr,
    output logic                          alu_in_valid,
    input  logic                          alu_out_valid,
    output logic                          rf_we,
    output logic [31:0]                   pc,
    output logic [31:0]                   retired,
    output logic                          halted,
    output logic [1:0]                    trap,
    output logic [2:0]                    state_dbg
);

    localparam int AW  = $clog2(IMEM_DEPTH);
    localparam int WCW = $clog2(ALU_TIMEOUT) + 1;
    localparam logic [31:0]    PC_LAST   = 32'(IMEM_DEPTH - 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(ALU_TIMEOUT - 1);

    seq_state_e     state_q;
    trap_cause_e    trap_q;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    instr_q;
    logic [31:0]    retired_q, retired_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           halted_q;
    logic           instr_legal;
    logic           done;

    assign instr_legal = is_legal_instr(instr_q);
    assign done        = (state_q == ST_WAIT) && alu_out_valid;
    assign pc_d        = pc_q + 32'd1;
    assign retired_d   = retired_q + 32'd1;
    assign wait_cnt_d  = wait_cnt_q + WCW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            trap_q     <= TRAP_NONE;
            pc_q       <= '0;
            instr_q    <= '0;
            retired_q  <= '0;
            wait_cnt_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    instr_q <= imem_data;
                    state_q <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (instr_legal) begin
                        wait_cnt_q <= '0;
                        state_q    <= ST_WAIT;
                    end else begin
                        trap_q   <= TRAP_ILLEGAL;
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end
                end
                ST_WAIT: begin
                    // A result on the last allowed cycle beats the watchdog.
                    if (alu_out_valid) begin
                        retired_q <= retired_d;
                        if (pc_q == PC_LAST) begin
                            trap_q   <= TRAP_PC_OVERFLOW;
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end else begin
                            pc_q    <= pc_d;
                            state_q <= stop ? ST_IDLE : ST_FETCH;
                        end
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        trap_q   <= TRAP_ALU_TIMEOUT;
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_addr    = pc_q[AW-1:0];
    assign instr        = instr_q;
    assign alu_in_valid = (state_q == ST_ISSUE) && instr_legal;
    // x0 is hardwired to zero, so its write is suppressed here.
    assign rf_we        = done && (instr_q[11:7] != 5'd0);
    assign pc           = pc_q;
    assign retired      = retired_q;
    assign halted       = halted_q;
    assign trap         = trap_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a synchronous instruction memory
// and a fixed-latency ALU responder.
module tb_instr_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    localparam logic [31:0] I_ADDI = 32'h0050_0093; // addi x1, x0, 5
    localparam logic [31:0] I_ADD  = 32'h0010_8133; // add  x2, x1, x1
    localparam logic [31:0] I_ZERO = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  imem_addr;
    logic [31:0] imem_data = '0;
    logic [31:0] instr;
    logic        alu_in_valid;
    logic        alu_out_valid;
    logic        rf_we;
    logic [31:0] pc;
    logic [31:0] retired;
    logic        halted;
    logic [1:0]  trap;
    logic [2:0]  state_dbg;

    logic [31:0] mem [DEPTH];
    int          alu_lat = 0;
    int          alu_cnt = 0;
    int          tests = 0;
    int          fails = 0;

    instr_sequencer #(.IMEM_DEPTH(DEPTH), .ALU_TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .instr         (instr),
        .alu_in_valid  (alu_in_valid),
        .alu_out_valid (alu_out_valid),
        .rf_we         (rf_we),
        .pc            (pc),
        .retired       (retired),
        .halted        (halted),
        .trap          (trap),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    // ALU responder: answers alu_lat cycles after the issue pulse; 0 = never.
    always @(posedge clk or posedge rst) begin
        if (rst)               alu_cnt <= 0;
        else if (alu_in_valid) alu_cnt <= alu_lat;
        else if (alu_cnt > 0)  alu_cnt <= alu_cnt - 1;
    end
    assign alu_out_valid = (alu_cnt == 1);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic fill_mem(input logic [31:0] w);
        for (int i = 0; i < DEPTH; i++) mem[i] = w;
    endtask

    logic [15:0] iv_log;
    logic [15:0] we_log;
    logic        we_seen;

    initial begin
        fill_mem(I_ADDI);
        tick(1);

        // Reset state
        do_reset();
        chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_pulses", {30'd0, alu_in_valid, rf_we}, 32'd0);

        // Two-instruction program, L=1; illegal word at 2 ends the run
        mem[0] = I_ADDI; mem[1] = I_ADD; mem[2] = I_ZERO; mem[3] = I_ZERO;
        alu_lat = 1;
        start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            iv_log[i] = alu_in_valid;
            we_log[i] = rf_we;
            tick(1);
        end
        chk("prog_issue_cycles", 32'(iv_log), 32'h0000_0088);
        chk("prog_rfwe_cycles", 32'(we_log), 32'h0000_0110);
        chk("prog_retired", retired, 32'd2);
        chk("prog_pc", pc, 32'd2);
        chk("prog_instr", instr, I_ZERO);
        chk("prog_trap", 32'(trap), 32'd1);

        // Illegal word at address 0
        do_reset();
        fill_mem(I_ZERO);
        start = 1'b1;
        iv_log = '0;
        for (int i = 0; i < 8; i++) begin
            iv_log[i] = alu_in_valid;
            tick(1);
        end
        chk("ill_no_issue", 32'(iv_log), 32'd0);
        chk("ill_halted", 32'(halted), 32'd1);
        chk("ill_trap", 32'(trap), 32'd1);
        chk("ill_retired", retired, 32'd0);
        chk("ill_state", 32'(state_dbg), 32'(S_HALT));

        // ALU never answers: trap 2 after 16 WAIT cycles
        do_reset();
        fill_mem(I_ADDI);
        alu_lat = 0;
        start = 1'b1;
        tick(3);
        chk("tmo_issue", 32'(alu_in_valid), 32'd1);
        tick(16);
        chk("tmo_not_yet", 32'(halted), 32'd0);
        chk("tmo_still_wait", 32'(state_dbg), 32'(S_WAIT));
        tick(1);
        chk("tmo_halted", 32'(halted), 32'd1);
        chk("tmo_trap", 32'(trap), 32'd2);
        chk("tmo_retired", retired, 32'd0);

        // ALU answers on the 16th WAIT cycle: completes normally
        do_reset();
        alu_lat = 16;
        start = 1'b1;
        tick(19);
        chk("late_rfwe", 32'(rf_we), 32'd1);
        chk("late_not_halted", 32'(halted), 32'd0);
        tick(1);
        chk("late_trap", 32'(trap), 32'd0);
        chk("late_retired", retired, 32'd1);
        chk("late_pc", pc, 32'd1);
        chk("late_state", 32'(state_dbg), 32'(S_FETCH));

        // stop during WAIT of instruction 0, then resume at address 1
        do_reset();
        alu_lat = 2;
        start = 1'b1;
        tick(4);
        chk("stop_in_wait", 32'(state_dbg), 32'(S_WAIT));
        start = 1'b0;
        stop  = 1'b1;
        tick(2);
        chk("stop_idle", 32'(state_dbg), 32'(S_IDLE));
        chk("stop_pc", pc, 32'd1);
        chk("stop_retired", retired, 32'd1);
        stop = 1'b0;
        tick(2);
        chk("stop_stays_idle", 32'(state_dbg), 32'(S_IDLE));
        start = 1'b1;
        tick(1);
        chk("resume_fetch", 32'(state_dbg), 32'(S_FETCH));
        chk("resume_addr", 32'(imem_addr), 32'd1);

        // PC overflow at the last memory word
        do_reset();
        alu_lat = 1;
        start = 1'b1;
        tick(16);
        chk("ovf_pre_halted", 32'(halted), 32'd0);
        chk("ovf_pre_pc", pc, 32'd3);
        chk("ovf_pre_retired", retired, 32'd3);
        tick(1);
        chk("ovf_halted", 32'(halted), 32'd1);
        chk("ovf_trap", 32'(trap), 32'd3);
        chk("ovf_pc", pc, 32'd3);
        chk("ovf_retired", retired, 32'd4);
        stop = 1'b1;
        tick(2);
        chk("ovf_absorbing", 32'(state_dbg), 32'(S_HALT));

        // Asynchronous reset in the middle of WAIT
        do_reset();
        alu_lat = 3;
        start = 1'b1;
        tick(10);
        chk("arst_pre_state", 32'(state_dbg), 32'(S_WAIT));
        chk("arst_pre_retired", retired, 32'd1);
        rst = 1'b1;
        start = 1'b0;
        #1;
        chk("arst_state", 32'(state_dbg), 32'(S_IDLE));
        chk("arst_pc", pc, 32'd0);
        chk("arst_retired", retired, 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_pulses", {30'd0, alu_in_valid, rf_we}, 32'd0);
        we_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            we_seen = we_seen | rf_we;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            we_seen = we_seen | rf_we;
        end
        chk("arst_no_rfwe", 32'(we_seen), 32'd0);
        chk("arst_post_state", 32'(state_dbg), 32'(S_IDLE));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
